serial_adder: RTL and testbench

Bit-serial N-bit adder built around a single 1-bit full-adder cell and a registered carry. It sits directly upstream of, and drives, the 1-bit full-adder cell: operands are captured in parallel through a valid/ready handshake, then presented to the cell one bit per clock, LSB first, with the cell's carry-out fed back through a flip-flop. The sum is reassembled in parallel and offered downstream through a second valid/ready handshake. The block trades area for latency: one adder cell serves the whole word width.

---
 rtl/serial_adder_pkg.sv | 8 +
 rtl/full_adder_cell.sv | 13 +
 rtl/serial_adder.sv | 125 ++++++++++++
 tb/tb_serial_adder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;

    localparam int unsigned SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit combinational full adder; the only arithmetic cell in serial_adder.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: parallel valid/ready capture, one bit per clock
// through a single full_adder_cell, parallel result offered downstream.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sa_state_t        state;
    sa_state_t        state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_co;
    logic             load;
    logic             step;
    logic             last_step;
    logic             release_out;

    full_adder_cell u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters at the MSB; written as shifts so WIDTH = 1 needs no special case.
    assign acc_nxt  = (acc >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
    assign in_ready = rst_n && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        load        = 1'b0;
        step        = 1'b0;
        last_step   = 1'b0;
        release_out = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST_BIT) begin
                    last_step = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    release_out = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand/sum shift registers, carry flop, bit counter and the held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (load) begin
                a_sh  <= a;
                b_sh  <= b;
                carry <= cin;
                cnt   <= '0;
            end
            if (step) begin
                a_sh  <= a_sh >> 1;
                b_sh  <= b_sh >> 1;
                acc   <= acc_nxt;
                carry <= fa_co;
                cnt   <= cnt + CNT_W'(1);
            end
            if (last_step) begin
                sum       <= acc_nxt;
                cout      <= fa_co;
                out_valid <= 1'b1;
            end
            if (release_out) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH = 8) against an a+b+cin scoreboard.
module tb_serial_adder;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    logic dir_ready;
    logic rnd_ready = 1'b1;
    logic rand_mode;
    assign out_ready = rand_mode ? rnd_ready : dir_ready;

    int n_tests  = 0;
    int n_fail   = 0;
    int in_hs    = 0;
    int out_hs   = 0;
    int n_drop   = 0;
    int cyc      = 0;
    int acc_prev = 0;
    int acc_last = 0;
    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] sb_e;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rnd_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: every accepted operand pair must come back once, in order, as a+b+cin.
    always @(negedge clk) begin
        if (!rst_n) begin
            n_drop += exp_q.size();
            exp_q.delete();
        end else begin
            check("excl_ready_valid", 64'(in_ready & out_valid), 64'd0);
            if (in_valid && in_ready) begin
                exp_q.push_back((WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(cin));
                in_hs++;
                acc_prev = acc_last;
                acc_last = cyc;
            end
            if (out_valid && out_ready) begin
                out_hs++;
                if (exp_q.size() == 0) begin
                    check("spurious_out_hs", 64'd1, 64'd0);
                end else begin
                    sb_e = exp_q.pop_front();
                    check("sb_sum", 64'(sum), 64'(sb_e[WIDTH-1:0]));
                    check("sb_cout", 64'(cout), 64'(sb_e[WIDTH]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                         input logic cc, input bit keep);
        a        = aa;
        b        = bb;
        cin      = cc;
        in_valid = 1'b1;
        accept();
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            lat++;
            if (out_valid) break;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 2000; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            tick();
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int lat;
        int h;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        dir_ready = 1'b1;
        rand_mode = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        rst_n = 1'b1;
        tick();
        check("idle_in_ready", 64'(in_ready), 64'd1);

        // Basic carry and latency
        issue(8'h0F, 8'h01, 1'b0, 1'b0);
        wait_valid(lat);
        check("basic_latency", 64'(lat), 64'd8);
        check("basic_sum", 64'(sum), 64'h10);
        check("basic_cout", 64'(cout), 64'd0);
        tick();
        check("post_hs_in_ready", 64'(in_ready), 64'd1);
        check("post_hs_out_valid", 64'(out_valid), 64'd0);

        // Wrap-around
        issue(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_valid(lat);
        check("wrap1_sum", 64'(sum), 64'h00);
        check("wrap1_cout", 64'(cout), 64'd1);
        tick();
        issue(8'hFF, 8'hFF, 1'b1, 1'b0);
        wait_valid(lat);
        check("wrap2_sum", 64'(sum), 64'hFF);
        check("wrap2_cout", 64'(cout), 64'd1);
        tick();

        // Backpressure with ignored in_valid pulses
        dir_ready = 1'b0;
        issue(8'h5A, 8'hC3, 1'b1, 1'b0);
        wait_valid(lat);
        check("bp_latency", 64'(lat), 64'd8);
        for (int i = 0; i < 5; i++) begin
            a        = 8'($urandom);
            b        = 8'($urandom);
            cin      = 1'($urandom);
            in_valid = 1'b1;
            tick();
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_sum", 64'(sum), 64'h1E);
            check("bp_cout", 64'(cout), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        h         = out_hs;
        dir_ready = 1'b1;
        tick();
        check("bp_one_hs", 64'(out_hs - h), 64'd1);
        check("bp_rel_out_valid", 64'(out_valid), 64'd0);
        check("bp_rel_in_ready", 64'(in_ready), 64'd1);

        // Reset in the middle of RUN
        issue(8'hFF, 8'h01, 1'b0, 1'b0);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_sum", 64'(sum), 64'd0);
        check("mid_rst_cout", 64'(cout), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        h = out_hs;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (12) tick();
        check("mid_rst_no_hs", 64'(out_hs - h), 64'd0);
        issue(8'h12, 8'h34, 1'b0, 1'b0);
        wait_valid(lat);
        check("post_rst_sum", 64'(sum), 64'h46);
        check("post_rst_cout", 64'(cout), 64'd0);
        tick();

        // Back-to-back with in_valid and out_ready held high
        issue(8'h80, 8'h80, 1'b0, 1'b1);
        a   = 8'h01;
        b   = 8'h02;
        cin = 1'b0;
        accept();
        in_valid = 1'b0;
        check("b2b_gap", 64'(acc_last - acc_prev), 64'd10);
        drain();

        // Random sweep with random downstream stalls
        rand_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a        = 8'($urandom);
            b        = 8'($urandom);
            cin      = 1'($urandom);
            in_valid = 1'b1;
            accept();
            in_valid = 1'b0;
            if ($urandom_range(0, 3) == 0) tick();
        end
        drain();
        rand_mode = 1'b0;
        check("hs_balance", 64'(out_hs + n_drop), 64'(in_hs));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
